// File: rtl/sum_uart_sequencer_if.sv
// sum_uart_sequencer_if: request/strobe/operand/UART signals of the sum
// sequencer. The slave modport is the sequencer itself; the master modport
// is whatever drives the requests and hosts the two operand latches.
interface sum_uart_sequencer_if #(
   parameter int DATA_W = 4
);
   logic              load_a;
   logic              load_b;
   logic              send;
   logic              save_a_n;
   logic              save_b_n;
   logic [DATA_W-1:0] q_a;
   logic [DATA_W-1:0] q_b;
   logic [DATA_W:0]   sum_out;
   logic              tx;
   logic              busy;

   modport master (
      output load_a, load_b, send, q_a, q_b,
      input  save_a_n, save_b_n, sum_out, tx, busy
   );

   modport slave (
      input  load_a, load_b, send, q_a, q_b,
      output save_a_n, save_b_n, sum_out, tx, busy
   );
endinterface

// File: rtl/sum_uart_sequencer.sv
// sum_uart_sequencer: strobes two external operand latches on request, adds
// the latched operands on a send request and transmits the sum as one UART
// byte (start bit, 8 data bits LSB first, stop bit).
// Define UART_PARITY_EN to insert an even parity bit before the stop bit.
module sum_uart_sequencer #(
   parameter int CLKS_PER_BIT = 104,
   parameter int DATA_W       = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   sum_uart_sequencer_if.slave bus
);

   localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      CAP_A,
      CAP_B,
      START,
      DATA,
`ifdef UART_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic              tx_q, tx_d;
   logic              save_a_n_q, save_a_n_d;
   logic              save_b_n_q, save_b_n_d;
   logic [DATA_W:0]   sum_q, sum_d;
   logic              load_a_prev_q, load_b_prev_q, send_prev_q;
   logic              pend_a_q, pend_a_d;
   logic              pend_b_q, pend_b_d;
   logic              pend_s_q, pend_s_d;

   logic              edge_a, edge_b, edge_s;
   logic              take_a, take_b, take_s;
   logic              bit_end;
   logic [7:0]        tx_byte;

   // A request edge is "was low last cycle, is high now".
   assign edge_a  = bus.load_a & ~load_a_prev_q;
   assign edge_b  = bus.load_b & ~load_b_prev_q;
   assign edge_s  = bus.send   & ~send_prev_q;
   assign bit_end = (cnt_q == CNT_LAST);

   // Byte on the wire is the sum zero-extended (or truncated) to 8 bits.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_tx_byte
         if (gi < DATA_W + 1) begin : g_sum_bit
            assign tx_byte[gi] = sum_q[gi];
         end else begin : g_zero_bit
            assign tx_byte[gi] = 1'b0;
         end
      end
   endgenerate

   // Next-state, output and pending-request logic.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_idx_d  = bit_idx_q;
      tx_d       = tx_q;
      save_a_n_d = 1'b1;
      save_b_n_d = 1'b1;
      sum_d      = sum_q;
      take_a     = 1'b0;
      take_b     = 1'b0;
      take_s     = 1'b0;

      case (state_q)
         IDLE: begin
            tx_d  = 1'b1;
            cnt_d = '0;
            if (pend_a_q) begin
               take_a     = 1'b1;
               save_a_n_d = 1'b0;
               state_d    = CAP_A;
            end else if (pend_b_q) begin
               take_b     = 1'b1;
               save_b_n_d = 1'b0;
               state_d    = CAP_B;
            end else if (pend_s_q) begin
               take_s  = 1'b1;
               sum_d   = {1'b0, bus.q_a} + {1'b0, bus.q_b};
               tx_d    = 1'b0;
               state_d = START;
            end
         end

         CAP_A, CAP_B: begin
            state_d = IDLE;
         end

         START: begin
            if (bit_end) begin
               cnt_d     = '0;
               bit_idx_d = 3'd0;
               tx_d      = tx_byte[0];
               state_d   = DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (bit_idx_q == 3'd7) begin
                  bit_idx_d = 3'd0;
`ifdef UART_PARITY_EN
                  tx_d    = ^tx_byte;
                  state_d = PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = tx_byte[bit_idx_q + 3'd1];
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

`ifdef UART_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               cnt_d   = '0;
               tx_d    = 1'b1;
               state_d = STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`endif

         STOP: begin
            tx_d = 1'b1;
            if (bit_end) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            tx_d    = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase

      // Edges are only remembered while idle; anything seen mid-operation is dropped.
      pend_a_d = (pend_a_q & ~take_a) | ((state_q == IDLE) & edge_a);
      pend_b_d = (pend_b_q & ~take_b) | ((state_q == IDLE) & edge_b);
      pend_s_d = (pend_s_q & ~take_s) | ((state_q == IDLE) & edge_s);
   end

   // All state, registered outputs and edge registers; reset aborts any frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         bit_idx_q     <= 3'd0;
         tx_q          <= 1'b1;
         save_a_n_q    <= 1'b1;
         save_b_n_q    <= 1'b1;
         sum_q         <= '0;
         load_a_prev_q <= 1'b0;
         load_b_prev_q <= 1'b0;
         send_prev_q   <= 1'b0;
         pend_a_q      <= 1'b0;
         pend_b_q      <= 1'b0;
         pend_s_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         bit_idx_q     <= bit_idx_d;
         tx_q          <= tx_d;
         save_a_n_q    <= save_a_n_d;
         save_b_n_q    <= save_b_n_d;
         sum_q         <= sum_d;
         load_a_prev_q <= bus.load_a;
         load_b_prev_q <= bus.load_b;
         send_prev_q   <= bus.send;
         pend_a_q      <= pend_a_d;
         pend_b_q      <= pend_b_d;
         pend_s_q      <= pend_s_d;
      end
   end

   assign bus.save_a_n = save_a_n_q;
   assign bus.save_b_n = save_b_n_q;
   assign bus.sum_out  = sum_q;
   assign bus.tx       = tx_q;
   assign bus.busy     = (state_q != IDLE) | pend_a_q | pend_b_q | pend_s_q;

endmodule

// File: tb/tb_sum_uart_sequencer.sv
// tb_sum_uart_sequencer: scoreboarded bench for sum_uart_sequencer with
// CLKS_PER_BIT=4, DATA_W=4. Hosts two operand latches, decodes tx with a
// UART receiver and compares received frames against expected frames.
// Honours UART_PARITY_EN the same way as the design.
module tb_sum_uart_sequencer;

   localparam int CPB = 4;
   localparam int DW  = 4;
`ifdef UART_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME_CYC = NBITS * CPB;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   logic [DW-1:0] din_a = '0;
   logic [DW-1:0] din_b = '0;
   logic [DW-1:0] lat_a = '0;
   logic [DW-1:0] lat_b = '0;

   int vectors     = 0;
   int miscompares = 0;

   logic [NBITS-1:0] exp_q[$];
   logic [NBITS-1:0] rx_q[$];

   sum_uart_sequencer_if #(.DATA_W(DW)) bus ();

   sum_uart_sequencer #(
      .CLKS_PER_BIT(CPB),
      .DATA_W      (DW)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // External operand latches, written while their strobe is low.
   always @(posedge clk) begin
      if (bus.save_a_n === 1'b0) lat_a <= din_a;
      if (bus.save_b_n === 1'b0) lat_b <= din_b;
   end
   assign bus.q_a = lat_a;
   assign bus.q_b = lat_b;

   // UART receiver: samples mid-bit on falling clock edges.
   logic             rx_active = 1'b0;
   int               rx_cnt    = 0;
   logic [NBITS-1:0] rx_bits   = '0;
   always @(negedge clk) begin
      if (!reset_n) begin
         rx_active <= 1'b0;
         rx_cnt    <= 0;
      end else if (!rx_active) begin
         if (bus.tx === 1'b0) begin
            rx_active <= 1'b1;
            rx_cnt    <= 1;
         end
      end else begin
         if (rx_cnt % CPB == 2) begin
            rx_bits[rx_cnt / CPB] <= bus.tx;
            if (rx_cnt / CPB == NBITS - 1) begin
               rx_q.push_back({bus.tx, rx_bits[NBITS-2:0]});
               rx_active <= 1'b0;
            end
         end
         rx_cnt <= rx_cnt + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   // Expected wire image: bit 0 is the start bit.
   function automatic logic [NBITS-1:0] make_frame(input logic [7:0] b);
      logic [NBITS-1:0] f;
      f = '0;
      for (int i = 0; i < 8; i++) f[1 + i] = b[i];
`ifdef UART_PARITY_EN
      f[9] = ^b;
`endif
      f[NBITS-1] = 1'b1;
      return f;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_frame(output logic got, output logic [NBITS-1:0] fr);
      got = 1'b0;
      fr  = '0;
      for (int k = 0; k < 4 * FRAME_CYC; k++) begin
         if (rx_q.size() != 0) begin
            got = 1'b1;
            fr  = rx_q.pop_front();
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      reset_n    = 1'b0;
      bus.load_a = 1'b0;
      bus.load_b = 1'b0;
      bus.send   = 1'b0;
      step();
      step();
      vectors++; if (bus.tx !== 1'b1)       begin miscompares++; $display("FAIL reset_tx: got %b expected 1", bus.tx); end
      vectors++; if (bus.save_a_n !== 1'b1) begin miscompares++; $display("FAIL reset_save_a_n: got %b expected 1", bus.save_a_n); end
      vectors++; if (bus.save_b_n !== 1'b1) begin miscompares++; $display("FAIL reset_save_b_n: got %b expected 1", bus.save_b_n); end
      vectors++; if (bus.sum_out !== 5'd0)  begin miscompares++; $display("FAIL reset_sum_out: got %0d expected 0", bus.sum_out); end
      vectors++; if (bus.busy !== 1'b0)     begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      reset_n = 1'b1;
      step();
      vectors++; if (bus.busy !== 1'b0)     begin miscompares++; $display("FAIL post_reset_busy: got %b expected 0", bus.busy); end
      $display("reset: outputs checked");
   endtask

   task automatic test_load_a(input logic [DW-1:0] va);
      din_a      = va;
      bus.load_a = 1'b1;
      vectors++; if (bus.busy !== 1'b0)     begin miscompares++; $display("FAIL load_a_busy0: got %b expected 0", bus.busy); end
      step();
      bus.load_a = 1'b0;
      vectors++; if (bus.busy !== 1'b1)     begin miscompares++; $display("FAIL load_a_busy1: got %b expected 1", bus.busy); end
      vectors++; if (bus.save_a_n !== 1'b1) begin miscompares++; $display("FAIL load_a_early: got %b expected 1", bus.save_a_n); end
      step();
      vectors++; if (bus.save_a_n !== 1'b0) begin miscompares++; $display("FAIL load_a_strobe: got %b expected 0", bus.save_a_n); end
      vectors++; if (bus.save_b_n !== 1'b1) begin miscompares++; $display("FAIL load_a_no_b: got %b expected 1", bus.save_b_n); end
      vectors++; if (bus.busy !== 1'b1)     begin miscompares++; $display("FAIL load_a_busy_cap: got %b expected 1", bus.busy); end
      step();
      vectors++; if (bus.save_a_n !== 1'b1) begin miscompares++; $display("FAIL load_a_release: got %b expected 1", bus.save_a_n); end
      vectors++; if (bus.busy !== 1'b0)     begin miscompares++; $display("FAIL load_a_idle: got %b expected 0", bus.busy); end
      vectors++; if (bus.q_a !== va)        begin miscompares++; $display("FAIL load_a_latch: got %h expected %h", bus.q_a, va); end
      $display("load_a %h: strobe checked", va);
   endtask

   task automatic test_load_both(input logic [DW-1:0] va, input logic [DW-1:0] vb);
      din_a      = va;
      din_b      = vb;
      bus.load_a = 1'b1;
      bus.load_b = 1'b1;
      step();
      bus.load_a = 1'b0;
      bus.load_b = 1'b0;
      step();
      vectors++; if ({bus.save_a_n, bus.save_b_n} !== 2'b01) begin miscompares++; $display("FAIL both_cap_a: got %b expected 01", {bus.save_a_n, bus.save_b_n}); end
      step();
      vectors++; if ({bus.save_a_n, bus.save_b_n} !== 2'b11) begin miscompares++; $display("FAIL both_gap: got %b expected 11", {bus.save_a_n, bus.save_b_n}); end
      vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL both_gap_busy: got %b expected 1", bus.busy); end
      step();
      vectors++; if ({bus.save_a_n, bus.save_b_n} !== 2'b10) begin miscompares++; $display("FAIL both_cap_b: got %b expected 10", {bus.save_a_n, bus.save_b_n}); end
      step();
      vectors++; if ({bus.save_a_n, bus.save_b_n} !== 2'b11) begin miscompares++; $display("FAIL both_end: got %b expected 11", {bus.save_a_n, bus.save_b_n}); end
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL both_idle: got %b expected 0", bus.busy); end
      vectors++; if ({bus.q_a, bus.q_b} !== {va, vb}) begin miscompares++; $display("FAIL both_latch: got %h expected %h", {bus.q_a, bus.q_b}, {va, vb}); end
      $display("load_both %h %h: strobes checked", va, vb);
   endtask

   task automatic test_send_frame(input logic [DW:0] exp_sum, input string tag);
      logic [NBITS-1:0] fr, rx, ex;
      logic             got;
      int               bad_tx, bad_busy;
      fr = make_frame(8'(exp_sum));
      exp_q.push_back(fr);
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL %s_idle_before: got %b expected 0", tag, bus.busy); end
      bus.send = 1'b1;
      step();
      bus.send = 1'b0;
      vectors++; if (bus.tx !== 1'b1) begin miscompares++; $display("FAIL %s_tx_pending: got %b expected 1", tag, bus.tx); end
      step();
      vectors++; if (bus.sum_out !== exp_sum) begin miscompares++; $display("FAIL %s_sum_out: got %0d expected %0d", tag, bus.sum_out, exp_sum); end
      bad_tx   = 0;
      bad_busy = 0;
      for (int i = 0; i < FRAME_CYC; i++) begin
         if (bus.tx !== fr[i / CPB]) bad_tx++;
         if (bus.busy !== 1'b1) bad_busy++;
         step();
      end
      vectors++; if (bad_tx != 0)   begin miscompares++; $display("FAIL %s_tx_bits: %0d wrong cycles, expected 0", tag, bad_tx); end
      vectors++; if (bad_busy != 0) begin miscompares++; $display("FAIL %s_busy_frame: %0d low cycles, expected 0", tag, bad_busy); end
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL %s_busy_end: got %b expected 0", tag, bus.busy); end
      vectors++; if (bus.tx !== 1'b1)   begin miscompares++; $display("FAIL %s_tx_idle: got %b expected 1", tag, bus.tx); end
      wait_frame(got, rx);
      ex = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      vectors++;
      if (!got) begin miscompares++; $display("FAIL %s_rx: no frame received, expected %b", tag, ex); end
      else if (rx !== ex) begin miscompares++; $display("FAIL %s_rx: got %b expected %b", tag, rx, ex); end
      else $display("%s: frame %b sum %0d received", tag, rx, exp_sum);
   endtask

   task automatic test_sum_frame();
      test_load_both(4'hF, 4'hF);
      test_send_frame(5'd30, "sum_ff");
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] pa[3];
      logic [DW-1:0] pb[3];
      pa = '{4'h3, 4'h0, 4'h8};
      pb = '{4'h5, 4'h0, 4'h9};
      for (int k = 0; k < 3; k++) begin
         test_load_both(pa[k], pb[k]);
         test_send_frame({1'b0, pa[k]} + {1'b0, pb[k]}, "b2b_load");
      end
      test_send_frame(5'd17, "b2b_resend");
      test_send_frame(5'd17, "b2b_resend2");
   endtask

   task automatic test_discard();
      logic [NBITS-1:0] fr, rx, ex;
      logic             got;
      int               bad_save, bad_busy, bad_idle;
      test_load_both(4'h6, 4'h2);
      fr = make_frame(8'd8);
      exp_q.push_back(fr);
      bus.send = 1'b1;
      step();
      bus.send = 1'b0;
      step();
      din_a    = 4'h9;
      bad_save = 0;
      bad_busy = 0;
      for (int t = 0; t < FRAME_CYC; t++) begin
         if (t == 12) bus.load_a = 1'b1;
         if (t == 14) bus.load_a = 1'b0;
         if (bus.save_a_n !== 1'b1) bad_save++;
         if (bus.busy !== 1'b1) bad_busy++;
         step();
      end
      vectors++; if (bad_save != 0) begin miscompares++; $display("FAIL discard_save_a_n: %0d low cycles, expected 0", bad_save); end
      vectors++; if (bad_busy != 0) begin miscompares++; $display("FAIL discard_busy_frame: %0d low cycles, expected 0", bad_busy); end
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL discard_busy_end: got %b expected 0", bus.busy); end
      bad_idle = 0;
      for (int t = 0; t < 4; t++) begin
         step();
         if (bus.busy !== 1'b0 || bus.save_a_n !== 1'b1) bad_idle++;
      end
      vectors++; if (bad_idle != 0) begin miscompares++; $display("FAIL discard_not_queued: %0d active cycles, expected 0", bad_idle); end
      vectors++; if (bus.q_a !== 4'h6) begin miscompares++; $display("FAIL discard_latch: got %h expected 6", bus.q_a); end
      wait_frame(got, rx);
      ex = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      vectors++;
      if (!got) begin miscompares++; $display("FAIL discard_rx: no frame received, expected %b", ex); end
      else if (rx !== ex) begin miscompares++; $display("FAIL discard_rx: got %b expected %b", rx, ex); end
      else $display("discard: frame %b received, load_a dropped", rx);
   endtask

   task automatic test_reset_mid();
      int bad_idle;
      test_load_both(4'hA, 4'h3);
      bus.send = 1'b1;
      step();
      bus.send = 1'b0;
      step();
      for (int t = 0; t < 17; t++) step();
      // now inside data bit 3
      reset_n = 1'b0;
      #1;
      vectors++; if (bus.tx !== 1'b1)       begin miscompares++; $display("FAIL midrst_tx: got %b expected 1", bus.tx); end
      vectors++; if (bus.busy !== 1'b0)     begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
      vectors++; if (bus.sum_out !== 5'd0)  begin miscompares++; $display("FAIL midrst_sum_out: got %0d expected 0", bus.sum_out); end
      vectors++; if (bus.save_a_n !== 1'b1) begin miscompares++; $display("FAIL midrst_save_a_n: got %b expected 1", bus.save_a_n); end
      exp_q.delete();
      step();
      step();
      reset_n  = 1'b1;
      bad_idle = 0;
      for (int t = 0; t < FRAME_CYC; t++) begin
         step();
         if (bus.tx !== 1'b1 || bus.busy !== 1'b0) bad_idle++;
      end
      vectors++; if (bad_idle != 0) begin miscompares++; $display("FAIL midrst_no_resume: %0d active cycles, expected 0", bad_idle); end
      vectors++; if (rx_q.size() != 0) begin miscompares++; $display("FAIL midrst_partial_frame: got %0d frames expected 0", rx_q.size()); end
      rx_q.delete();
      $display("reset mid-frame: abort checked");
      test_send_frame(5'd13, "post_reset");
   endtask

   initial begin
      bus.load_a = 1'b0;
      bus.load_b = 1'b0;
      bus.send   = 1'b0;
      test_reset();
      test_load_a(4'h5);
      test_load_both(4'hC, 4'h7);
      test_sum_frame();
      test_back_to_back();
      test_discard();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sum_uart_sequencer.md
SUM_UART_SEQUENCER -- requirements
Module: sum_uart_sequencer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, clock cycles per UART bit; legal range 2..65535.
REQ-002 SHALL have parameter DATA_W, default 4, operand width; the sum width is DATA_W+1.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 load_a  input  1  request to capture operand A; rising-edge detected.
REQ-006 load_b  input  1  request to capture operand B; rising-edge detected.
REQ-007 send  input  1  request to transmit the sum; rising-edge detected.
REQ-008 save_a_n  output  1  active-low one-cycle capture strobe to operand latch A.
REQ-009 save_b_n  output  1  active-low one-cycle capture strobe to operand latch B.
REQ-010 q_a  input  DATA_W  latched operand A, returned from the latch.
REQ-011 q_b  input  DATA_W  latched operand B, returned from the latch.
REQ-012 sum_out  output  DATA_W+1  registered sum, valid after the most recent send was accepted.
REQ-013 tx  output  1  UART serial output; idles high.
REQ-014 busy  output  1  high while any capture or transmission is in progress.

Function
REQ-015 SHALL implement FSM states IDLE, CAP_A, CAP_B, START, DATA, PARITY, STOP; PARITY is present only per REQ-031.
REQ-016 Edge detection SHALL register each request input once; an edge is registered input low and current input high.
REQ-017 Requests SHALL be accepted only in IDLE; edges seen in any other state SHALL be discarded, not queued.
REQ-018 A load_a edge in IDLE SHALL move to CAP_A; save_a_n SHALL be low for exactly the one cycle in CAP_A; the FSM SHALL then return to IDLE.
REQ-019 A load_b edge in IDLE SHALL move to CAP_B; save_b_n SHALL be low for exactly the one cycle in CAP_B; the FSM SHALL then return to IDLE.
REQ-020 Simultaneous edges in IDLE SHALL be prioritised load_a > load_b > send.
REQ-021 A lower-priority edge arriving with a higher one SHALL be held pending and serviced on the next IDLE cycle, in priority order.
REQ-022 A send edge in IDLE SHALL register sum_out = q_a + q_b, zero-extended with no overflow loss (max 2^(DATA_W+1)-2), on the accepting edge, and SHALL enter START.
REQ-023 The transmitted byte SHALL be sum_out zero-extended to 8 bits and sent LSB first.
REQ-024 The UART frame SHALL be: start bit 0, 8 data bits, optional parity bit, stop bit 1; each bit lasts exactly CLKS_PER_BIT cycles.
REQ-025 tx SHALL fall on the clock edge after send is accepted.
REQ-026 After the stop bit completes, the FSM SHALL return to IDLE and tx SHALL remain 1.
REQ-027 busy SHALL be 0 only in IDLE with no pending request; busy SHALL be combinationally derived from state and pending flags.
REQ-028 The baud counter SHALL count 0..CLKS_PER_BIT-1 and reset to 0 at each bit boundary; the bit index SHALL wrap 7->0 on leaving DATA.

Reset
REQ-029 reset_n low SHALL immediately force: state IDLE, tx=1, save_a_n=1, save_b_n=1, sum_out=0, busy=0, all counters and pending flags cleared, edge registers cleared.
REQ-030 Reset asserted mid-frame SHALL abort the frame with tx=1 at once; no partial frame SHALL resume after release.

Configuration
REQ-031 Macro UART_PARITY_EN: when defined, a PARITY state SHALL follow DATA and transmit even parity (XOR of the 8 data bits) for one bit period; frame length is 11 bits. When undefined, DATA SHALL go directly to STOP; frame length is 10 bits.

Verification (CLKS_PER_BIT=4, DATA_W=4)
REQ-032 Pulse load_a -> save_a_n low for exactly 1 cycle, 2 cycles after the edge; busy high during CAP_A.
REQ-033 Assert load_a and load_b in the same cycle -> save_a_n strobe, then save_b_n strobe on the following CAP_B; never both low together.
REQ-034 q_a=4'hF, q_b=4'hF, pulse send -> sum_out=5'd30; tx carries 0,0,1,1,1,1,0,0,0,1 at 4 cycles per bit (LSB first); busy falls after 40 cycles.
REQ-035 Same stimulus with UART_PARITY_EN defined -> parity bit 0 before stop; frame 44 cycles.
REQ-036 Pulse send, then load_a during DATA -> save_a_n stays 1 and the load_a edge is discarded; busy falls on schedule.
REQ-037 Drop reset_n during DATA bit 3 -> tx=1, busy=0, and sum_out=0 in the same cycle; a new send after release produces a complete, correct frame.
